// File: rtl/edge_capture_bank.sv
// edge_capture_bank: per-channel synchroniser + mode-selected edge detector with pulse, sticky flag and saturating counter
// Ports:
//   clock  - single clock, all state updates on posedge
//   reset  - asynchronous active-high, clears all state at once
//   d      - raw asynchronous inputs, one per channel
//   mode   - per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   clear  - per-channel synchronous clear of flag and count (an edge in the same cycle wins)
//   q      - synchronised channel value (last sync stage)
//   a      - registered one-cycle edge pulse
//   flag   - sticky edge-seen flag
//   count  - saturating event counters, channel i at [i*CNT_W +: CNT_W]
module edge_capture_bank #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       d,
  input  logic [2*WIDTH-1:0]     mode,
  input  logic [WIDTH-1:0]       clear,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       flag,
  output logic [WIDTH*CNT_W-1:0] count
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] qp_q, a_q, flag_q, flag_d, rise, fall, hit;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  assign q     = sync_q[SYNC_STAGES-1];
  assign a     = a_q;
  assign flag  = flag_q;
  assign count = cnt_q;
  assign rise  = q & ~qp_q;
  assign fall  = ~q & qp_q;
  always_comb begin
    sync_d[0] = d;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    hit    = '0;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i]    = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
      flag_d[i] = hit[i] ? 1'b1 : clear[i] ? 1'b0 : flag_q[i];
      cnt_d[i]  = clear[i] ? (hit[i] ? CNT_W'(1) : '0)
                : (hit[i] && cnt_q[i] != {CNT_W{1'b1}}) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      qp_q   <= '0;
      a_q    <= '0;
      flag_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      qp_q   <= q;
      a_q    <= hit;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_edge_capture_bank.sv
// tb_edge_capture_bank: randomized and directed checks of edge_capture_bank against a behavioural model
module tb_edge_capture_bank;
  localparam int W = 4, S = 2, C = 3;
  localparam int MAXC = (1 << C) - 1;
  logic clock = 0, reset = 1;
  logic [W-1:0] d = '0, clear = '0;
  logic [2*W-1:0] mode = '1;
  logic [W-1:0] q, a, flag;
  logic [W*C-1:0] count;
  int checks = 0, failures = 0;
  logic [W-1:0] dq[$];
  logic [W-1:0] mq, pm, ma, mf;
  int mc[W];
  edge_capture_bank #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(C)) dut (
    .clock(clock), .reset(reset), .d(d), .mode(mode), .clear(clear),
    .q(q), .a(a), .flag(flag), .count(count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    dq = {};
    repeat (S) dq.push_back('0);
    mq = '0; pm = '0; ma = '0; mf = '0;
    foreach (mc[i]) mc[i] = 0;
  endtask
  task automatic model_step();
    for (int i = 0; i < W; i++) begin
      bit r, f, h;
      r = mq[i] && !pm[i];
      f = !mq[i] && pm[i];
      h = (mode[2*i] && r) || (mode[2*i+1] && f);
      ma[i] = h;
      if (clear[i]) begin
        mf[i] = h;
        mc[i] = h ? 1 : 0;
      end else if (h) begin
        mf[i] = 1'b1;
        if (mc[i] < MAXC) mc[i]++;
      end
    end
    pm = mq;
    dq.push_front(d);
    void'(dq.pop_back());
    mq = dq[S-1];
  endtask
  task automatic check_all(input string ph);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("%s_q%0d", ph, i), q[i], mq[i]);
      chk($sformatf("%s_a%0d", ph, i), a[i], ma[i]);
      chk($sformatf("%s_flag%0d", ph, i), flag[i], mf[i]);
      chk($sformatf("%s_cnt%0d", ph, i), count[i*C +: C], mc[i]);
    end
  endtask
  task automatic step(input string ph, input logic [W-1:0] nd, input logic [2*W-1:0] nm, input logic [W-1:0] nc);
    d = nd; mode = nm; clear = nc;
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_all(ph);
  endtask
  task automatic hold(input string ph, input logic [W-1:0] nd, input logic [2*W-1:0] nm, input int n);
    repeat (n) step(ph, nd, nm, '0);
  endtask
  initial begin
    logic [W-1:0] rd;
    logic [2*W-1:0] rm;
    model_reset();
    #2 check_all("rst");
    @(negedge clock);
    reset = 0;
    hold("idle", 4'b0000, '1, 2);
    step("t1", 4'b0001, '1, '0);
    step("t1", 4'b0001, '1, '0);
    step("t1", 4'b0001, '1, '0);
    chk("t1_a0_pulse", a, 4'b0001);
    hold("t1", 4'b0001, '1, 3);
    chk("t1_cnt", count, 12'h001);
    chk("t1_flag", flag, 4'b0001);
    hold("rise", 4'b0011, 8'b1111_0111, 3);
    hold("rise", 4'b0001, 8'b1111_0111, 3);
    chk("rise_cnt1", count[C +: C], 1);
    hold("fall", 4'b0011, 8'b1111_1011, 3);
    hold("fall", 4'b0001, 8'b1111_1011, 3);
    chk("fall_cnt1", count[C +: C], 2);
    hold("off", 4'b0011, 8'b1111_0011, 3);
    hold("off", 4'b0001, 8'b1111_0011, 3);
    chk("off_cnt1", count[C +: C], 2);
    hold("clr", 4'b0101, '1, 4);
    hold("clr", 4'b0001, '1, 4);
    chk("clr_pre", count[2*C +: C], 2);
    step("clr", 4'b0001, '1, 4'b0100);
    chk("clr_flag2", flag[2], 0);
    chk("clr_cnt2", count[2*C +: C], 0);
    step("clrhit", 4'b0101, '1, '0);
    step("clrhit", 4'b0101, '1, '0);
    step("clrhit", 4'b0101, '1, 4'b0100);
    chk("clrhit_flag2", flag[2], 1);
    chk("clrhit_cnt2", count[2*C +: C], 1);
    for (int k = 0; k < 9; k++) hold("sat", (k % 2 == 0) ? 4'b1101 : 4'b0101, '1, 3);
    chk("sat_cnt3", count[3*C +: C], MAXC);
    step("arst", 4'b0100, '1, '0);
    #2 reset = 1;
    #1 model_reset();
    check_all("arst");
    d = 4'b0001; mode = 8'h55; clear = '0;
    @(negedge clock);
    reset = 0;
    hold("rel", 4'b0001, 8'h55, 4);
    chk("rel_cnt", count, 12'h001);
    hold("sim", 4'b0000, 8'h55, 3);
    step("sim", 4'b1111, 8'h55, '0);
    step("sim", 4'b1111, 8'h55, '0);
    step("sim", 4'b1111, 8'h55, '0);
    chk("sim_a", a, 4'b1111);
    step("sim", 4'b1111, 8'h55, '0);
    chk("sim_a_off", a, 4'b0000);
    chk("sim_cnt", count, {3'd1, 3'd1, 3'd1, 3'd2});
    rd = d; rm = mode;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(2) == 0) rd[i] = ~rd[i];
      if ($urandom_range(20) == 0) rm = 2*W'($urandom);
      step("rnd", rd, rm, ($urandom_range(7) == 0) ? W'($urandom) & W'($urandom) : '0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
